effective_address_sequencer: RTL and testbench

Sequences the shared arithmetic unit to form a 16-bit indexed effective address (base + 8-bit index), as used by the abs,X / abs,Y / zp,X addressing modes.
- Low byte uses the ALU ADR0 op. High byte uses the ALU ADR1 op, which adds the ALU's internally registered carry.
- Sits between the instruction decoder/address logic and the arithmetic unit.
- Owns the ALU only while busy. The CPU datapath muxes the ALU inputs on alu_own.

---
 rtl/effective_address_sequencer.sv | 147 ++++++++++++++
 tb/tb_effective_address_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/effective_address_sequencer.sv
// rtl/effective_address_sequencer.sv - Drives the shared ALU through low/high adds to form base+index.
// Optional PAGE_CROSS_SKIP_EN: skip the high-byte add when the low-byte add does not carry.
module effective_address_sequencer #(
    parameter logic [1:0] ADR0_OP = 2'b00,
    parameter logic [1:0] ADR1_OP = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base,
    input  logic [7:0]  index,
    input  logic        zp_mode,
    output logic        busy,
    output logic        done,
    output logic [15:0] addr,
    output logic        page_cross,
    output logic        alu_own,
    output logic [1:0]  alu_opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  base_hi_q, base_hi_d;
    logic        zp_q, zp_d;
    logic [15:0] addr_q, addr_d;
    logic        page_cross_q, page_cross_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        alu_own_q, alu_own_d;
    logic [1:0]  alu_opcode_q, alu_opcode_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;

    // ALU drive is registered one state ahead so it is stable for the whole LO/HI cycle;
    // the low base byte and index live only in alu_a_q/alu_b_q during LO.
    always_comb begin
        state_d      = state_q;
        base_hi_d    = base_hi_q;
        zp_d         = zp_q;
        addr_d       = addr_q;
        page_cross_d = page_cross_q;
        done_d       = 1'b0;
        alu_opcode_d = 2'b00;
        alu_a_d      = 8'h00;
        alu_b_d      = 8'h00;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_hi_d    = base[15:8];
                    zp_d         = zp_mode;
                    state_d      = LO;
                    alu_opcode_d = ADR0_OP;
                    alu_a_d      = base[7:0];
                    alu_b_d      = index;
                end
            end
            LO: begin
                addr_d[7:0] = alu_out;
                if (zp_q) begin
                    addr_d[15:8] = 8'h00;
                    page_cross_d = 1'b0;
                    state_d      = DONE;
                    done_d       = 1'b1;
                end
`ifdef PAGE_CROSS_SKIP_EN
                else if (!alu_carry) begin
                    addr_d[15:8] = base_hi_q;
                    page_cross_d = 1'b0;
                    state_d      = DONE;
                    done_d       = 1'b1;
                end
`endif
                else begin
                    // HI must follow immediately: the ALU keeps only last cycle's carry.
                    page_cross_d = alu_carry;
                    state_d      = HI;
                    alu_opcode_d = ADR1_OP;
                    alu_a_d      = 8'h00;
                    alu_b_d      = base_hi_q;
                end
            end
            HI: begin
                addr_d[15:8] = alu_out;
                state_d      = DONE;
                done_d       = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        alu_own_d = (state_d == LO) || (state_d == HI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            base_hi_q    <= 8'h00;
            zp_q         <= 1'b0;
            addr_q       <= 16'h0000;
            page_cross_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            alu_own_q    <= 1'b0;
            alu_opcode_q <= 2'b00;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            base_hi_q    <= base_hi_d;
            zp_q         <= zp_d;
            addr_q       <= addr_d;
            page_cross_q <= page_cross_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            alu_own_q    <= alu_own_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign addr       = addr_q;
    assign page_cross = page_cross_q;
    assign alu_own    = alu_own_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_effective_address_sequencer.sv
// tb/tb_effective_address_sequencer.sv - Random and directed checks of effective_address_sequencer.
module tb_effective_address_sequencer;

`ifdef PAGE_CROSS_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base = 16'h0000;
    logic [7:0]  index = 8'h00;
    logic        zp_mode = 1'b0;
    logic        busy, done, page_cross, alu_own, alu_carry;
    logic [15:0] addr;
    logic [1:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_carry_reg = 1'b0;

    int tests = 0;
    int fails = 0;

    effective_address_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base       (base),
        .index      (index),
        .zp_mode    (zp_mode),
        .busy       (busy),
        .done       (done),
        .addr       (addr),
        .page_cross (page_cross),
        .alu_own    (alu_own),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry)
    );

    always #5 clk = ~clk;

    // Shared ALU: ADR0 = a + b, ADR1 = a + b + carry registered from the previous cycle.
    always_comb begin
        {alu_carry, alu_out} = 9'h000;
        case (alu_opcode)
            2'b00:   {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_reg};
            default: {alu_carry, alu_out} = 9'h000;
        endcase
    end

    always @(posedge clk) alu_carry_reg <= alu_carry;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] b, input logic [7:0] i, input logic z, input bit noise);
        logic [15:0] exp_addr;
        logic [7:0]  lo;
        int          sum;
        bit          exp_pc;
        int          exp_lat;
        int          own_cnt = 0;
        bit          saw_adr1 = 1'b0;
        int          done_cyc = 0;

        sum      = int'(b[7:0]) + int'(i);
        lo       = b[7:0] + i;
        exp_pc   = !z && (sum > 255);
        exp_addr = z ? {8'h00, lo} : (b + {8'h00, i});
        exp_lat  = z ? 2 : ((SKIP && !exp_pc) ? 2 : 3);

        @(negedge clk);
        start = 1'b1; base = b; index = i; zp_mode = z;
        for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("lo_opcode", alu_opcode, 2'b00);
                check("lo_a", alu_a, b[7:0]);
                check("lo_b", alu_b, i);
            end
            if (alu_own) own_cnt++;
            if (alu_own && alu_opcode == 2'b01) begin
                saw_adr1 = 1'b1;
                check("hi_b", alu_b, b[15:8]);
            end
            check("busy_during", busy, 1'b1);
            if (done) done_cyc = c;
            if (noise && !done) begin
                start = 1'($urandom); base = 16'($urandom); index = 8'($urandom); zp_mode = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", done_cyc, exp_lat);
        check("addr", addr, exp_addr);
        check("page_cross", page_cross, exp_pc);
        check("alu_own_cycles", own_cnt, exp_lat - 1);
        check("adr1_used", saw_adr1, exp_lat == 3);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("addr_hold", addr, exp_addr);
    endtask

    initial begin
        int done_seen;
        int d;

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", addr, 16'h0000);
        check("rst_own", alu_own, 1'b0);
        check("rst_opcode", alu_opcode, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h12F0, 8'h20, 1'b0, 1'b0);
        run_op(16'h1234, 8'h05, 1'b0, 1'b0);
        run_op(16'h00F0, 8'h20, 1'b1, 1'b0);
        run_op(16'hFFFF, 8'h01, 1'b0, 1'b0);
        run_op(16'h10FF, 8'hFF, 1'b1, 1'b1);
        run_op(16'h4000, 8'h00, 1'b0, 1'b1);

        // Reset while the high-byte add is in flight.
        @(negedge clk);
        start = 1'b1; base = 16'h12F0; index = 8'h20; zp_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_hi", alu_opcode, 2'b01);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_own", alu_own, 1'b0);
        check("mid_rst_addr", addr, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("no_done_after_rst", done_seen, 0);
        run_op(16'h2000, 8'h10, 1'b0, 1'b0);

        // start held high through DONE: re-accepted only from IDLE.
        @(negedge clk);
        start = 1'b1; base = 16'h30F8; index = 8'h10; zp_mode = 1'b0;
        d = 0;
        for (int c = 1; c <= 8 && d == 0; c++) begin
            @(negedge clk);
            if (done) d = c;
        end
        check("held_latency", d, 3);
        check("held_addr", addr, 16'h3108);
        @(negedge clk);
        check("held_idle_gap", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("held_restart", busy, 1'b1);
        d = 0;
        for (int c = 2; c <= 8 && d == 0; c++) begin
            @(negedge clk);
            if (done) d = c;
        end
        check("held_second_latency", d, 3);
        check("held_second_addr", addr, 16'h3108);
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            run_op(16'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
